ctrl_rfseq: RTL and testbench
=============================

Name: ctrl_rfseq

Overview:
- Sequencer directly upstream of the register-file address driver in the SRC controller.
- Accepts one input sample per handshake and steps through a fixed per-sample schedule: unload sample, calc init, TAPS-1 tap reads, load error, load result.
- Each step drives the en / rf_rw / res_err / get_logic / result_logic / error_logic controls the driver consumes.
- Owns the circular sample-slot pointer and the tap counter, and signals completion via a valid/ready output handshake.

Parameters:
- WIDTH, 3, register-file address width.
- RING, 6, number of sample slots (addresses 0..RING-1); RING <= 2**WIDTH-2.
- TAPS, 4, taps per output sample; 2 <= TAPS <= RING.
- ERR_ADDR, 6, error/accumulator register address; must be >= RING.
- RES_ADDR, 7, result register address; must be >= RING and != ERR_ADDR.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  new sample present on the datapath.
- in_ready  out  1  sequencer can accept a sample.
- out_valid  out  1  result register holds a finished output.
- out_ready  in  1  consumer took the result.
- en  out  1  enable to the address driver.
- rf_rw  out  1  1 = read step, 0 = write step.
- res_err  out  1  write target select: 1 = result_logic, 0 = error_logic.
- get_logic  out  1  1 = single-operand read of result_logic.
- result_logic  out  WIDTH  sample/result address.
- error_logic  out  WIDTH  error/accumulator address.
- stage  out  4  current step code, for datapath sequencing.
- busy  out  1  schedule in progress (not IDLE and not DONE).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, wr_ptr=0, tap counter=0.
  - All outputs 0, including in_ready.
  - Asserting rst mid-schedule aborts immediately; no partial write is issued after rst rises.
  - First IDLE cycle after rst falls: in_ready=1.
- All outputs decode from registered state/pointers only; there is no combinational input-to-output path.
- States: IDLE, ULOAD, CINIT, CALC, LERR, LRES, DONE.
- IDLE:
  - in_ready=1, en=0, rf_rw=1, others 0, stage=0000.
  - in_valid&&in_ready at an edge: latch p=wr_ptr, go to ULOAD.
- ULOAD, 1 cycle:
  - en=1, rf_rw=0, res_err=1, result_logic=p, stage=1000.
  - Exit: wr_ptr <= (p==RING-1) ? 0 : p+1. Go to CINIT.
- CINIT, 1 cycle:
  - en=1, rf_rw=1, get_logic=1, result_logic=p, error_logic=ERR_ADDR, stage=0101.
  - Next: CALC, k=1.
- CALC, TAPS-1 cycles, k=1..TAPS-1:
  - en=1, rf_rw=1, get_logic=0, stage=0101.
  - idx=(p-k) mod RING, computed with wrap (no negative underflow).
  - result_logic=idx+1, so the downstream result_logic-1 lands on idx.
  - error_logic=ERR_ADDR.
  - k==TAPS-1 -> LERR.
- LERR, 1 cycle:
  - en=1, rf_rw=0, res_err=0, error_logic=ERR_ADDR, stage=0010.
- LRES, 1 cycle:
  - en=1, rf_rw=0, res_err=1, result_logic=RES_ADDR, stage=0001.
- DONE:
  - en=0, out_valid=1, in_ready=0, stage=0000.
  - Holds until out_ready, then IDLE.
  - out_valid&&out_ready and in_valid in the same cycle: the new sample is not accepted that cycle. It is accepted on the next IDLE cycle.
- Latency: accept edge E0 -> ULOAD in cycle E0+1 -> out_valid first high in cycle E0+TAPS+4 (TAPS=4: cycle 8).
- Throughput: one sample per TAPS+5 cycles minimum.
- Don't-care address fields are driven to 0. Never Z.
- busy=1 in ULOAD..LRES.
- in_valid is ignored outside IDLE.

Decomposition:
- Shared controller package holds:
  - 4-bit stage codes: ULOAD_SAMPLE=1000, CALC_INIT=0101, LOAD_ERROR=0010, LOAD_RESULT=0001, IDLE=0000.
  - state enum typedef.
- One natural sub-module: ctrl_ringidx, a combinational modulo-RING subtract/increment for wr_ptr advance and idx.
- Everything else is a single FSM plus counters.

Test Plan:
- Reset then idle: rst pulse -> all outputs 0; one cycle after release in_ready=1, busy=0, en=0.
- Single sample, defaults, wr_ptr=0, accept at E0:
  - ULOAD: result_logic=0.
  - CINIT: result_logic=0, get_logic=1.
  - CALC result_logic = 6, 5, 4 (idx 5, 4, 3), error_logic=6.
  - LERR: error_logic=6.
  - LRES: result_logic=7.
  - out_valid at E0+8.
- Wrap: 6 back-to-back samples with out_ready=1 -> ULOAD result_logic=0,1,2,3,4,5; 7th sample writes slot 0. Sample 3 (p=2) CALC result_logic = 2, 1, 6.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid stays 1, en=0, in_ready=0, in_valid ignored. out_ready=1 -> IDLE next cycle, accept the following cycle.
- Mid-schedule reset: assert rst during CALC k=2 -> outputs 0 asynchronously, no LERR/LRES issued. After release, next accept uses p=0.
- TAPS=6, RING=6: CALC visits all 5 other slots exactly once. result_logic never exceeds RING, never equals 0.

Source files
------------

// File: rtl/ctrl_rfseq_pkg.sv
// Shared definitions for the register-file sequencer: stage codes seen by the
// datapath and the FSM state type.
package ctrl_rfseq_pkg;

   localparam logic [3:0] IDLE         = 4'b0000;
   localparam logic [3:0] ULOAD_SAMPLE = 4'b1000;
   localparam logic [3:0] CALC_INIT    = 4'b0101;
   localparam logic [3:0] LOAD_ERROR   = 4'b0010;
   localparam logic [3:0] LOAD_RESULT  = 4'b0001;

   typedef enum logic [2:0] {
      StIdle,
      StUload,
      StCinit,
      StCalc,
      StLerr,
      StLres,
      StDone
   } state_e;

endpackage

// File: rtl/ctrl_rfseq_ringidx.sv
// Combinational modulo-RING arithmetic on sample-slot indices: base-offset with
// wrap, and base+1 with wrap. Both operands are assumed to be below RING.
module ctrl_ringidx #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned RING  = 6
) (
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] offset,
   output logic [WIDTH-1:0] dec,
   output logic [WIDTH-1:0] inc
);

   localparam logic [WIDTH-1:0] RingN    = WIDTH'(RING);
   localparam logic [WIDTH-1:0] RingLast = WIDTH'(RING - 1);

   always_comb begin
      // base+RING may wrap past 2**WIDTH; the final result is still < RING.
      if (base >= offset) begin
         dec = base - offset;
      end else begin
         dec = base + RingN - offset;
      end
      inc = (base == RingLast) ? '0 : base + WIDTH'(1);
   end

endmodule

// File: rtl/ctrl_rfseq.sv
// Per-sample register-file schedule sequencer: unload, calc init, tap reads,
// load error, load result, then a valid/ready hand-off of the finished result.
module ctrl_rfseq
   import ctrl_rfseq_pkg::*;
#(
   parameter int unsigned WIDTH    = 3,
   parameter int unsigned RING     = 6,
   parameter int unsigned TAPS     = 4,
   parameter int unsigned ERR_ADDR = 6,
   parameter int unsigned RES_ADDR = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             en,
   output logic             rf_rw,
   output logic             res_err,
   output logic             get_logic,
   output logic [WIDTH-1:0] result_logic,
   output logic [WIDTH-1:0] error_logic,
   output logic [3:0]       stage,
   output logic             busy
);

   localparam logic [WIDTH-1:0] ErrAddr = WIDTH'(ERR_ADDR);
   localparam logic [WIDTH-1:0] ResAddr = WIDTH'(RES_ADDR);
   localparam logic [WIDTH-1:0] LastTap = WIDTH'(TAPS - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic             run_q;
   logic [WIDTH-1:0] idx;
   logic [WIDTH-1:0] ptr_next;

   ctrl_ringidx #(
      .WIDTH (WIDTH),
      .RING  (RING)
   ) u_ringidx (
      .base   (p_q),
      .offset (k_q),
      .dec    (idx),
      .inc    (ptr_next)
   );

   // run_q holds every output at 0 while in reset and until the first edge after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         p_q      <= '0;
         k_q      <= '0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         p_q      <= p_d;
         k_q      <= k_d;
         run_q    <= 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      p_d      = p_q;
      k_d      = k_q;
      unique case (state_q)
         StIdle: begin
            if (run_q && in_valid) begin
               p_d     = wr_ptr_q;
               state_d = StUload;
            end
         end
         StUload: begin
            wr_ptr_d = ptr_next;
            state_d  = StCinit;
         end
         StCinit: begin
            k_d     = WIDTH'(1);
            state_d = StCalc;
         end
         StCalc: begin
            if (k_q == LastTap) begin
               k_d     = '0;
               state_d = StLerr;
            end else begin
               k_d = k_q + WIDTH'(1);
            end
         end
         StLerr: state_d = StLres;
         StLres: state_d = StDone;
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      en           = 1'b0;
      rf_rw        = 1'b0;
      res_err      = 1'b0;
      get_logic    = 1'b0;
      result_logic = '0;
      error_logic  = '0;
      stage        = IDLE;
      busy         = 1'b0;
      if (run_q) begin
         unique case (state_q)
            StIdle: begin
               in_ready = 1'b1;
               rf_rw    = 1'b1;
            end
            StUload: begin
               en           = 1'b1;
               res_err      = 1'b1;
               result_logic = p_q;
               stage        = ULOAD_SAMPLE;
               busy         = 1'b1;
            end
            StCinit: begin
               en           = 1'b1;
               rf_rw        = 1'b1;
               get_logic    = 1'b1;
               result_logic = p_q;
               error_logic  = ErrAddr;
               stage        = CALC_INIT;
               busy         = 1'b1;
            end
            StCalc: begin
               // Driver subtracts one from result_logic, so present idx+1.
               en           = 1'b1;
               rf_rw        = 1'b1;
               result_logic = idx + WIDTH'(1);
               error_logic  = ErrAddr;
               stage        = CALC_INIT;
               busy         = 1'b1;
            end
            StLerr: begin
               en          = 1'b1;
               error_logic = ErrAddr;
               stage       = LOAD_ERROR;
               busy        = 1'b1;
            end
            StLres: begin
               en           = 1'b1;
               res_err      = 1'b1;
               result_logic = ResAddr;
               stage        = LOAD_RESULT;
               busy         = 1'b1;
            end
            StDone: out_valid = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_rfseq.sv
// Scoreboard bench for ctrl_rfseq: a TAPS=4 instance and a TAPS=6 instance
// sharing clock and reset.
module tb_ctrl_rfseq;

   typedef struct packed {
      logic [3:0] stage;
      logic       rf_rw;
      logic       res_err;
      logic       get_logic;
      logic [2:0] rl;
      logic [2:0] el;
   } step_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a, en_a, rf_rw_a, res_err_a;
   logic       get_a, busy_a;
   logic [2:0] rl_a, el_a;
   logic [3:0] stage_a;
   logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b, en_b, rf_rw_b, res_err_b;
   logic       get_b, busy_b;
   logic [2:0] rl_b, el_b;
   logic [3:0] stage_b;
   step_t      obs_a, obs_b;

   int    total = 0;
   int    bad = 0;
   step_t q_a[$];
   step_t q_b[$];

   always #5 clk = ~clk;

   ctrl_rfseq u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid_a),
      .in_ready     (in_ready_a),
      .out_valid    (out_valid_a),
      .out_ready    (out_ready_a),
      .en           (en_a),
      .rf_rw        (rf_rw_a),
      .res_err      (res_err_a),
      .get_logic    (get_a),
      .result_logic (rl_a),
      .error_logic  (el_a),
      .stage        (stage_a),
      .busy         (busy_a)
   );

   ctrl_rfseq #(
      .WIDTH    (3),
      .RING     (6),
      .TAPS     (6),
      .ERR_ADDR (6),
      .RES_ADDR (7)
   ) u_dut6 (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid_b),
      .in_ready     (in_ready_b),
      .out_valid    (out_valid_b),
      .out_ready    (out_ready_b),
      .en           (en_b),
      .rf_rw        (rf_rw_b),
      .res_err      (res_err_b),
      .get_logic    (get_b),
      .result_logic (rl_b),
      .error_logic  (el_b),
      .stage        (stage_b),
      .busy         (busy_b)
   );

   assign obs_a = {stage_a, rf_rw_a, res_err_a, get_a, rl_a, el_a};
   assign obs_b = {stage_b, rf_rw_b, res_err_b, get_b, rl_b, el_b};

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Expected enabled steps of one sample starting at slot p (RING=6, ERR=6, RES=7).
   task automatic push_model(input int p, input int taps, input bit to_b);
      step_t s;
      int    idx;
      s = {4'b1000, 1'b0, 1'b1, 1'b0, 3'(p), 3'd0};
      if (to_b) q_b.push_back(s); else q_a.push_back(s);
      s = {4'b0101, 1'b1, 1'b0, 1'b1, 3'(p), 3'd6};
      if (to_b) q_b.push_back(s); else q_a.push_back(s);
      for (int k = 1; k < taps; k++) begin
         idx = (p - k + 6) % 6;
         s = {4'b0101, 1'b1, 1'b0, 1'b0, 3'(idx + 1), 3'd6};
         if (to_b) q_b.push_back(s); else q_a.push_back(s);
      end
      s = {4'b0010, 1'b0, 1'b0, 1'b0, 3'd0, 3'd6};
      if (to_b) q_b.push_back(s); else q_a.push_back(s);
      s = {4'b0001, 1'b0, 1'b1, 1'b0, 3'd7, 3'd0};
      if (to_b) q_b.push_back(s); else q_a.push_back(s);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      out_ready_a = 1'b0;
      out_ready_b = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      q_a.delete();
      q_b.delete();
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      out_ready_a = 1'b0;
      out_ready_b = 1'b0;
      cyc();
      cyc();
      total++;
      if ({en_a, in_ready_a, out_valid_a, rf_rw_a, res_err_a, get_a, busy_a, rl_a, el_a, stage_a}
          !== 20'd0) begin
         bad++;
         $display("FAIL reset_outputs_a: got %h want 0", {en_a, in_ready_a, out_valid_a, rf_rw_a,
                  res_err_a, get_a, busy_a, rl_a, el_a, stage_a});
      end
      total++;
      if ({en_b, in_ready_b, out_valid_b, rf_rw_b, res_err_b, get_b, busy_b, rl_b, el_b, stage_b}
          !== 20'd0) begin
         bad++;
         $display("FAIL reset_outputs_b: got %h want 0", {en_b, in_ready_b, out_valid_b, rf_rw_b,
                  res_err_b, get_b, busy_b, rl_b, el_b, stage_b});
      end
      rst = 1'b0;
      cyc();
      total++;
      if (in_ready_a !== 1'b1) begin
         bad++; $display("FAIL idle_in_ready: got %b want 1", in_ready_a);
      end
      total++;
      if (busy_a !== 1'b0) begin
         bad++; $display("FAIL idle_busy: got %b want 0", busy_a);
      end
      total++;
      if (en_a !== 1'b0) begin
         bad++; $display("FAIL idle_en: got %b want 0", en_a);
      end
      total++;
      if ({rf_rw_a, stage_a} !== 5'b10000) begin
         bad++; $display("FAIL idle_rfrw_stage: got %b want 10000", {rf_rw_a, stage_a});
      end
   endtask

   task automatic test_single();
      step_t exp;
      int    lat = 0;
      push_model(0, 4, 1'b0);
      in_valid_a = 1'b1;
      cyc();
      in_valid_a = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (out_valid_a) begin
            lat = c;
            break;
         end
         if (en_a) begin
            total++;
            if (q_a.size() == 0) begin
               bad++; $display("FAIL single_extra_step: got %h want none", obs_a);
            end else begin
               exp = q_a.pop_front();
               if (obs_a !== exp) begin
                  bad++; $display("FAIL single_step: got %h want %h", obs_a, exp);
               end
            end
         end
         cyc();
      end
      total++;
      if (lat !== 8) begin
         bad++; $display("FAIL single_latency: got %0d want 8", lat);
      end
      total++;
      if (q_a.size() !== 0) begin
         bad++; $display("FAIL single_missing: got %0d left want 0", q_a.size());
      end
      total++;
      if ({en_a, in_ready_a, busy_a, stage_a} !== 7'd0) begin
         bad++; $display("FAIL done_outputs: got %b want 0", {en_a, in_ready_a, busy_a, stage_a});
      end
      out_ready_a = 1'b1;
      cyc();
      out_ready_a = 1'b0;
      total++;
      if ({in_ready_a, out_valid_a} !== 2'b10) begin
         bad++; $display("FAIL done_release: got %b want 10", {in_ready_a, out_valid_a});
      end
   endtask

   task automatic test_wrap();
      step_t exp;
      int    p = 0;
      int    acc = 0;
      int    last = 0;
      do_reset();
      in_valid_a = 1'b1;
      out_ready_a = 1'b1;
      for (int c = 0; c < 120; c++) begin
         if (en_a) begin
            total++;
            if (q_a.size() == 0) begin
               bad++; $display("FAIL wrap_extra_step: got %h want none", obs_a);
            end else begin
               exp = q_a.pop_front();
               if (obs_a !== exp) begin
                  bad++; $display("FAIL wrap_step: got %h want %h", obs_a, exp);
               end
            end
         end
         if (in_valid_a && in_ready_a) begin
            push_model(p, 4, 1'b0);
            p = (p + 1) % 6;
            if (acc > 0) begin
               total++;
               if (c - last !== 9) begin
                  bad++; $display("FAIL wrap_throughput: got %0d want 9", c - last);
               end
            end
            last = c;
            acc++;
         end
         cyc();
         if (acc == 7) in_valid_a = 1'b0;
         if (acc == 7 && q_a.size() == 0) break;
      end
      total++;
      if (acc !== 7) begin
         bad++; $display("FAIL wrap_accepts: got %0d want 7", acc);
      end
      total++;
      if (q_a.size() !== 0) begin
         bad++; $display("FAIL wrap_missing: got %0d left want 0", q_a.size());
      end
      out_ready_a = 1'b0;
   endtask

   task automatic test_backpressure();
      bit seen = 1'b0;
      do_reset();
      in_valid_a = 1'b1;
      cyc();
      in_valid_a = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (out_valid_a) begin
            seen = 1'b1;
            break;
         end
         cyc();
      end
      total++;
      if (seen !== 1'b1) begin
         bad++; $display("FAIL bp_reach_done: got %b want 1", seen);
      end
      for (int c = 0; c < 10; c++) begin
         in_valid_a = c[0];
         total++;
         if ({out_valid_a, en_a, in_ready_a, busy_a, stage_a} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL bp_hold: got %b want 10000000",
                     {out_valid_a, en_a, in_ready_a, busy_a, stage_a});
         end
         cyc();
      end
      in_valid_a = 1'b1;
      out_ready_a = 1'b1;
      cyc();
      out_ready_a = 1'b0;
      total++;
      if ({in_ready_a, out_valid_a, stage_a} !== 6'b100000) begin
         bad++;
         $display("FAIL bp_idle: got %b want 100000", {in_ready_a, out_valid_a, stage_a});
      end
      cyc();
      in_valid_a = 1'b0;
      total++;
      if ({stage_a, rl_a} !== {4'b1000, 3'd1}) begin
         bad++; $display("FAIL bp_accept: got %b want 1000001", {stage_a, rl_a});
      end
   endtask

   task automatic test_midreset();
      do_reset();
      in_valid_a = 1'b1;
      cyc();
      in_valid_a = 1'b0;
      cyc();
      cyc();
      cyc();
      total++;
      if ({stage_a, get_a, rl_a} !== {4'b0101, 1'b0, 3'd5}) begin
         bad++; $display("FAIL mr_calc_k2: got %b want 01010101", {stage_a, get_a, rl_a});
      end
      rst = 1'b1;
      #1;
      total++;
      if ({en_a, in_ready_a, out_valid_a, rf_rw_a, res_err_a, get_a, busy_a, rl_a, el_a, stage_a}
          !== 20'd0) begin
         bad++;
         $display("FAIL mr_async_zero: got %h want 0", {en_a, in_ready_a, out_valid_a, rf_rw_a,
                  res_err_a, get_a, busy_a, rl_a, el_a, stage_a});
      end
      for (int c = 0; c < 3; c++) begin
         cyc();
         total++;
         if ({en_a, stage_a} !== 5'd0) begin
            bad++; $display("FAIL mr_no_write: got %b want 00000", {en_a, stage_a});
         end
      end
      rst = 1'b0;
      cyc();
      total++;
      if (in_ready_a !== 1'b1) begin
         bad++; $display("FAIL mr_ready: got %b want 1", in_ready_a);
      end
      in_valid_a = 1'b1;
      cyc();
      in_valid_a = 1'b0;
      total++;
      if ({stage_a, rl_a} !== {4'b1000, 3'd0}) begin
         bad++; $display("FAIL mr_restart_p0: got %b want 1000000", {stage_a, rl_a});
      end
   endtask

   task automatic test_taps6();
      step_t    exp;
      int       p = 0;
      int       acc = 0;
      int       cur_p = 0;
      int       ix;
      logic [5:0] mask = '0;
      do_reset();
      in_valid_b = 1'b1;
      out_ready_b = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (en_b) begin
            total++;
            if (q_b.size() == 0) begin
               bad++; $display("FAIL t6_extra_step: got %h want none", obs_b);
            end else begin
               exp = q_b.pop_front();
               if (obs_b !== exp) begin
                  bad++; $display("FAIL t6_step: got %h want %h", obs_b, exp);
               end
            end
            if (stage_b == 4'b1000) begin
               cur_p = int'(rl_b);
               mask = '0;
            end else if (stage_b == 4'b0101 && !get_b) begin
               total++;
               if (rl_b == 3'd0 || rl_b > 3'd6) begin
                  bad++; $display("FAIL t6_range: got %0d want 1..6", rl_b);
               end else begin
                  ix = int'(rl_b) - 1;
                  total++;
                  if (mask[ix] !== 1'b0) begin
                     bad++; $display("FAIL t6_revisit: got slot %0d twice want once", ix);
                  end
                  mask[ix] = 1'b1;
               end
            end else if (stage_b == 4'b0010) begin
               total++;
               if (mask !== (6'h3f & ~(6'b1 << cur_p))) begin
                  bad++;
                  $display("FAIL t6_cover: got %b want %b", mask, 6'h3f & ~(6'b1 << cur_p));
               end
            end
         end
         if (in_valid_b && in_ready_b) begin
            push_model(p, 6, 1'b1);
            p = (p + 1) % 6;
            acc++;
         end
         cyc();
         if (acc == 6) in_valid_b = 1'b0;
         if (acc == 6 && q_b.size() == 0) break;
      end
      total++;
      if (acc !== 6 || q_b.size() !== 0) begin
         bad++; $display("FAIL t6_complete: got acc=%0d left=%0d want 6/0", acc, q_b.size());
      end
      out_ready_b = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_backpressure();
      test_midreset();
      test_taps6();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
